// File: rtl/bus_arbiter_if.sv
// Two-master / one-slave bus bundle. The arbiter takes the slave modport;
// the environment (masters plus slave model) takes the master modport.
interface bus_arbiter_if;
    logic        m0_breq, m0_bstart, m0_ttype;
    logic [1:0]  m0_tsize;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_bdone, m0_berr, m0_bgnt;

    logic        m1_breq, m1_bstart, m1_ttype;
    logic [1:0]  m1_tsize;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_bdone, m1_berr, m1_bgnt;

    logic        s_bstart, s_ttype;
    logic [1:0]  s_tsize;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_bdone;

    modport slave (
        input  m0_breq, m0_bstart, m0_ttype, m0_tsize, m0_addr, m0_wdata,
        input  m1_breq, m1_bstart, m1_ttype, m1_tsize, m1_addr, m1_wdata,
        input  s_rdata, s_bdone,
        output m0_rdata, m0_bdone, m0_berr, m0_bgnt,
        output m1_rdata, m1_bdone, m1_berr, m1_bgnt,
        output s_bstart, s_ttype, s_tsize, s_addr, s_wdata
    );

    modport master (
        output m0_breq, m0_bstart, m0_ttype, m0_tsize, m0_addr, m0_wdata,
        output m1_breq, m1_bstart, m1_ttype, m1_tsize, m1_addr, m1_wdata,
        output s_rdata, s_bdone,
        input  m0_rdata, m0_bdone, m0_berr, m0_bgnt,
        input  m1_rdata, m1_bdone, m1_berr, m1_bgnt,
        input  s_bstart, s_ttype, s_tsize, s_addr, s_wdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between a data master (m0) and an instruction master (m1)
// sharing one slave, with an optional per-transfer timeout.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    bus_arbiter_if.slave  bus_io
);
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic owned, sel1, own_breq, own_bstart, tmo_hit;

    assign owned      = (state_q == OWN0) || (state_q == OWN1);
    assign sel1       = (state_q == OWN1);
    assign own_breq   = sel1 ? bus_io.m1_breq   : bus_io.m0_breq;
    assign own_bstart = sel1 ? bus_io.m1_bstart : bus_io.m0_bstart;
    // A master that withdraws its request aborts silently, even on the timeout cycle.
    assign tmo_hit    = (TIMEOUT != 0) && owned && own_breq && !bus_io.s_bdone &&
                        (cnt_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus_io.m0_breq && bus_io.m1_breq) state_d = last_q ? OWN0 : OWN1;
                else if (bus_io.m0_breq)              state_d = OWN0;
                else if (bus_io.m1_breq)              state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (bus_io.s_bdone) begin
                    state_d = IDLE;
                    last_d  = sel1;
                end else if (!own_breq) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    last_d  = sel1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_io.s_bstart = 1'b0;
        bus_io.s_ttype  = 1'b0;
        bus_io.s_tsize  = 2'b0;
        bus_io.s_addr   = 32'h0;
        bus_io.s_wdata  = 32'h0;
        bus_io.m0_rdata = 32'h0;
        bus_io.m0_bdone = 1'b0;
        bus_io.m0_berr  = 1'b0;
        bus_io.m0_bgnt  = 1'b0;
        bus_io.m1_rdata = 32'h0;
        bus_io.m1_bdone = 1'b0;
        bus_io.m1_berr  = 1'b0;
        bus_io.m1_bgnt  = 1'b0;
        if (owned) begin
            bus_io.s_bstart = own_bstart && !tmo_hit;
            bus_io.s_ttype  = sel1 ? bus_io.m1_ttype : bus_io.m0_ttype;
            bus_io.s_tsize  = sel1 ? bus_io.m1_tsize : bus_io.m0_tsize;
            bus_io.s_addr   = sel1 ? bus_io.m1_addr  : bus_io.m0_addr;
            bus_io.s_wdata  = sel1 ? bus_io.m1_wdata : bus_io.m0_wdata;
        end
        if (state_q == OWN0) begin
            bus_io.m0_rdata = bus_io.s_rdata;
            bus_io.m0_bdone = bus_io.s_bdone || tmo_hit;
            bus_io.m0_berr  = tmo_hit;
            bus_io.m0_bgnt  = 1'b1;
        end
        if (state_q == OWN1) begin
            bus_io.m1_rdata = bus_io.s_rdata;
            bus_io.m1_bdone = bus_io.s_bdone || tmo_hit;
            bus_io.m1_berr  = tmo_hit;
            bus_io.m1_bgnt  = 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario bench for bus_arbiter (TIMEOUT=4); completions are matched against
// an expectation queue filled as each scenario is set up.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          mst;
        logic        berr;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    bus_arbiter_if bif();

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bif.m0_breq = 0; bif.m0_bstart = 0; bif.m0_ttype = 0; bif.m0_tsize = 0;
        bif.m0_addr = 0; bif.m0_wdata = 0;
        bif.m1_breq = 0; bif.m1_bstart = 0; bif.m1_ttype = 0; bif.m1_tsize = 0;
        bif.m1_addr = 0; bif.m1_wdata = 0;
        bif.s_rdata = 0; bif.s_bdone = 0;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst = 1;
        bif.m0_breq = 1; bif.m1_breq = 1; bif.m0_bstart = 1; bif.m1_bstart = 1;
        bif.m0_addr = 32'h1111; bif.m1_addr = 32'h2222;
        bif.s_rdata = 32'h1234; bif.s_bdone = 1;
        @(negedge clk);
        checks++;
        if (bif.m0_bgnt !== 0 || bif.m1_bgnt !== 0)
            begin errors++; $display("FAIL reset_gnt: got %b%b want 00", bif.m1_bgnt, bif.m0_bgnt); end
        checks++;
        if (bif.s_bstart !== 0 || bif.s_addr !== 0)
            begin errors++; $display("FAIL reset_slave: got bstart=%b addr=%h want 0", bif.s_bstart, bif.s_addr); end
        checks++;
        if (bif.m0_rdata !== 0 || bif.m1_bdone !== 0 || bif.m0_berr !== 0)
            begin errors++; $display("FAIL reset_master: got rdata=%h bdone=%b berr=%b want 0", bif.m0_rdata, bif.m1_bdone, bif.m0_berr); end
        // s_bdone while idle with no requests must be ignored
        bif.m0_breq = 0; bif.m1_breq = 0;
        step();
        rst = 0;
        step();
        @(negedge clk);
        checks++;
        if (bif.m0_bdone !== 0 || bif.m1_bdone !== 0 || bif.m0_bgnt !== 0 || bif.m1_bgnt !== 0)
            begin errors++; $display("FAIL idle_bdone: got bdone=%b%b gnt=%b%b want 0", bif.m1_bdone, bif.m0_bdone, bif.m1_bgnt, bif.m0_bgnt); end
        checks++;
        if (bif.s_addr !== 0 || bif.s_rdata !== 32'h1234 || bif.m1_rdata !== 0)
            begin errors++; $display("FAIL idle_outputs: got s_addr=%h m1_rdata=%h want 0", bif.s_addr, bif.m1_rdata); end
        bif.s_bdone = 0;
        step();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int own = 0, idle = 0, grants = 0, done_n = 0, cur = 0;
        clr_inputs();
        bif.m0_addr = 32'h1000; bif.m1_addr = 32'h2000;
        bif.m0_bstart = 1; bif.m1_bstart = 1;
        bif.m0_breq = 1; bif.m1_breq = 1;
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 4; i++)
            sbq.push_back('{mst: i % 2, berr: 1'b0, rdata: (i % 2) ? 32'h2001 : 32'h1001});
        for (int cyc = 0; cyc < 60 && done_n < 4; cyc++) begin
            step();
            bif.s_bdone = 0;
            if (bif.m0_bgnt || bif.m1_bgnt) begin
                if (own == 0) begin
                    cur = bif.m1_bgnt ? 1 : 0;
                    checks++;
                    if (sbq.size() == 0 || sbq[0].mst != cur)
                        begin errors++; $display("FAIL rr_order: got m%0d want m%0d", cur, sbq.size() ? sbq[0].mst : -1); end
                    if (grants > 0) begin
                        checks++;
                        if (idle != 1) begin errors++; $display("FAIL rr_gap: got %0d idle cycles want 1", idle); end
                    end
                    checks++;
                    if (bif.s_addr !== (cur ? 32'h2000 : 32'h1000))
                        begin errors++; $display("FAIL rr_addr: got %h want %h", bif.s_addr, cur ? 32'h2000 : 32'h1000); end
                    grants++;
                end
                own++; idle = 0;
                if (own == 3) begin
                    bif.s_bdone = 1;
                    bif.s_rdata = bif.s_addr + 1;
                end
            end else begin
                own = 0; idle++;
            end
            @(negedge clk);
            if (bif.s_bdone) begin
                checks++;
                if (sbq.size() == 0) begin errors++; $display("FAIL rr_extra: got completion want none"); end
                else begin
                    e = sbq.pop_front();
                    if ((cur ? bif.m1_bdone : bif.m0_bdone) !== 1 ||
                        (cur ? bif.m1_rdata : bif.m0_rdata) !== e.rdata ||
                        (cur ? bif.m0_rdata : bif.m1_rdata) !== 0)
                        begin errors++; $display("FAIL rr_done: got m%0d rdata=%h want %h", cur, cur ? bif.m1_rdata : bif.m0_rdata, e.rdata); end
                end
                done_n++;
            end
        end
        checks++;
        if (done_n != 4) begin errors++; $display("FAIL rr_count: got %0d transfers want 4", done_n); end
        step();
        bif.m0_breq = 0; bif.m1_breq = 0; bif.s_bdone = 0;
        sbq.delete();
        step();
    endtask

    task automatic test_read_m1();
        exp_t e;
        int n;
        clr_inputs();
        bif.m0_addr = 32'h55;
        bif.m1_addr = 32'h100; bif.m1_ttype = 0; bif.m1_tsize = 2'd2;
        bif.m1_bstart = 1; bif.m1_breq = 1;
        sbq.push_back('{mst: 1, berr: 1'b0, rdata: 32'hDEADBEEF});
        for (n = 0; n < 10 && !bif.m1_bgnt; n++) step();
        @(negedge clk);
        checks++;
        if (bif.m1_bgnt !== 1 || bif.m0_bgnt !== 0)
            begin errors++; $display("FAIL rd_gnt: got %b%b want 10", bif.m1_bgnt, bif.m0_bgnt); end
        checks++;
        if (bif.s_addr !== 32'h100 || bif.s_tsize !== 2'd2 || bif.s_ttype !== 0 || bif.s_bstart !== 1)
            begin errors++; $display("FAIL rd_pass: got addr=%h size=%0d want 100/2", bif.s_addr, bif.s_tsize); end
        step();
        bif.s_bdone = 1; bif.s_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (!bif.m1_bdone) begin errors++; $display("FAIL rd_done: got bdone=0 want 1"); end
        else begin
            e = sbq.pop_front();
            if (bif.m1_rdata !== e.rdata || bif.m1_berr !== e.berr)
                begin errors++; $display("FAIL rd_data: got %h berr=%b want %h", bif.m1_rdata, bif.m1_berr, e.rdata); end
        end
        checks++;
        if (bif.m0_rdata !== 0 || bif.m0_bdone !== 0)
            begin errors++; $display("FAIL rd_other: got m0_rdata=%h want 0", bif.m0_rdata); end
        step();
        bif.s_bdone = 0; bif.m1_breq = 0;
        @(negedge clk);
        checks++;
        if (bif.m1_bdone !== 0 || bif.m1_bgnt !== 0)
            begin errors++; $display("FAIL rd_after: got bdone=%b gnt=%b want 0", bif.m1_bdone, bif.m1_bgnt); end
        sbq.delete();
        step();
    endtask

    task automatic test_timeout();
        exp_t e;
        int own = 0, idle = 0, grants = 0, done_n = 0, cur = 0, got;
        clr_inputs();
        bif.m0_bstart = 1; bif.m1_bstart = 1;
        bif.m0_breq = 1; bif.m1_breq = 1;
        sbq.push_back('{mst: 0, berr: 1'b1, rdata: 32'h0});
        sbq.push_back('{mst: 1, berr: 1'b0, rdata: 32'h77});
        for (int cyc = 0; cyc < 40 && done_n < 2; cyc++) begin
            step();
            bif.s_bdone = 0;
            if (bif.m0_bgnt || bif.m1_bgnt) begin
                if (own == 0) begin
                    cur = bif.m1_bgnt ? 1 : 0;
                    if (grants > 0) begin
                        checks++;
                        if (idle != 1) begin errors++; $display("FAIL to_gap: got %0d idle cycles want 1", idle); end
                    end
                    grants++;
                end
                own++; idle = 0;
                if (cur == 1 && own == 4) begin bif.s_bdone = 1; bif.s_rdata = 32'h77; end
            end else begin
                own = 0; idle++;
            end
            @(negedge clk);
            if (cur == 0 && own > 0) begin
                checks++;
                if (bif.s_bstart !== (own < 4))
                    begin errors++; $display("FAIL to_bstart: cycle %0d got %b want %b", own, bif.s_bstart, own < 4); end
            end
            if (bif.m0_bdone || bif.m1_bdone) begin
                got = bif.m1_bdone ? 1 : 0;
                checks++;
                if (sbq.size() == 0) begin errors++; $display("FAIL to_extra: got completion m%0d want none", got); end
                else begin
                    e = sbq.pop_front();
                    if (got != e.mst || (got ? bif.m1_berr : bif.m0_berr) !== e.berr || own != 4 ||
                        (!e.berr && bif.m1_rdata !== e.rdata))
                        begin errors++; $display("FAIL to_done: got m%0d berr=%b cycle %0d want m%0d berr=%b cycle 4",
                              got, got ? bif.m1_berr : bif.m0_berr, own, e.mst, e.berr); end
                end
                done_n++;
            end
        end
        checks++;
        if (done_n != 2) begin errors++; $display("FAIL to_count: got %0d completions want 2", done_n); end
        step();
        bif.m0_breq = 0; bif.m1_breq = 0; bif.s_bdone = 0;
        sbq.delete();
        step();
    endtask

    task automatic test_abort();
        clr_inputs();
        bif.m0_bstart = 1; bif.m1_bstart = 1;
        bif.m0_breq = 1; bif.m1_breq = 1;
        step();
        @(negedge clk);
        checks++;
        if (bif.m0_bgnt !== 1) begin errors++; $display("FAIL ab_gnt: got m0_bgnt=%b want 1", bif.m0_bgnt); end
        step();
        bif.m0_breq = 0;
        @(negedge clk);
        checks++;
        if (bif.m0_bdone !== 0 || bif.m0_berr !== 0)
            begin errors++; $display("FAIL ab_pulse: got bdone=%b berr=%b want 0", bif.m0_bdone, bif.m0_berr); end
        step();
        bif.m0_breq = 1;
        @(negedge clk);
        checks++;
        if (bif.m0_bgnt !== 0 || bif.m1_bgnt !== 0 || bif.m0_bdone !== 0)
            begin errors++; $display("FAIL ab_idle: got gnt=%b%b want 00", bif.m1_bgnt, bif.m0_bgnt); end
        step();
        @(negedge clk);
        checks++;
        if (bif.m0_bgnt !== 1 || bif.m1_bgnt !== 0)
            begin errors++; $display("FAIL ab_tie: got gnt=%b%b want 01", bif.m1_bgnt, bif.m0_bgnt); end
        step();
        bif.m0_breq = 0; bif.m1_breq = 0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        clr_inputs();
        bif.m1_bstart = 1; bif.m1_breq = 1; bif.m0_bstart = 1;
        for (n = 0; n < 10 && !bif.m1_bgnt; n++) step();
        @(negedge clk);
        checks++;
        if (bif.s_bstart !== 1 || bif.m1_bgnt !== 1)
            begin errors++; $display("FAIL rm_own: got bstart=%b gnt=%b want 1", bif.s_bstart, bif.m1_bgnt); end
        #1;
        rst = 1; bif.s_bdone = 1;
        #1;
        checks++;
        if (bif.s_bstart !== 0 || bif.m1_bgnt !== 0 || bif.m1_bdone !== 0 || bif.m1_berr !== 0)
            begin errors++; $display("FAIL rm_drop: got bstart=%b gnt=%b bdone=%b want 0", bif.s_bstart, bif.m1_bgnt, bif.m1_bdone); end
        step();
        bif.s_bdone = 0; bif.m0_breq = 1; bif.m1_breq = 1;
        rst = 0;
        step();
        @(negedge clk);
        checks++;
        if (bif.m0_bgnt !== 1 || bif.m1_bgnt !== 0)
            begin errors++; $display("FAIL rm_tie: got gnt=%b%b want 01", bif.m1_bgnt, bif.m0_bgnt); end
        step();
        bif.m0_breq = 0; bif.m1_breq = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read_m1();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles a granted transfer may wait for s_bdone; 0 disables timeout.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have ports mN_breq  input  1  master N (N=0 data bus, N=1 instruction bus) requests ownership.
REQ-005 SHALL have ports mN_bstart  input  1  master N starts/holds transfer.
REQ-006 SHALL have ports mN_ttype  input  1  0=READ, 1=WRITE.
REQ-007 SHALL have ports mN_tsize  input  2  transfer size code (byte/half/word), passed through unchanged.
REQ-008 SHALL have ports mN_addr, mN_wdata  input  32  address, write data.
REQ-009 SHALL have ports mN_rdata  output  32  read data to master N.
REQ-010 SHALL have ports mN_bdone, mN_berr, mN_bgnt  output  1  done pulse, timeout-error pulse, grant.
REQ-011 SHALL have ports s_bstart, s_ttype  output  1; s_tsize  output  2; s_addr, s_wdata  output  32  shared slave port.
REQ-012 SHALL have ports s_rdata  input  32; s_bdone  input  1  slave read data, one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, OWN0, OWN1, plus 1-bit register last (last completed owner) and timeout counter cnt of width clog2(TIMEOUT+1).
REQ-014 In IDLE: only m0_breq -> OWN0; only m1_breq -> OWN1; both -> grant master != last; none -> stay IDLE.
REQ-015 Grant is registered: mN_bgnt=1 exactly while state is OWNN, from cycle after arbitration decision.
REQ-016 In OWNN, s_bstart/s_ttype/s_tsize/s_addr/s_wdata SHALL combinationally equal master N's signals; mN_rdata=s_rdata, mN_bdone=s_bdone.
REQ-017 Non-owner (and both masters in IDLE): rdata=0, bdone=0, berr=0, bgnt=0; in IDLE all s_* outputs = 0.
REQ-018 In OWNN, s_bdone=1 -> next state IDLE, last<=N; no back-to-back grant, min one IDLE cycle between transfers.
REQ-019 In OWNN, mN_breq=0 with s_bdone=0 -> abort: next state IDLE, last unchanged, no bdone/berr.
REQ-020 cnt clears to 0 on entry to OWNN, increments each OWNN cycle without s_bdone, saturating.
REQ-021 TIMEOUT!=0 and cnt==TIMEOUT-1 with s_bdone=0 -> mN_berr=1 and mN_bdone=1 for that cycle, s_bstart forced 0, next state IDLE, last<=N.
REQ-022 s_bdone and timeout in same cycle -> normal completion, berr=0.
REQ-023 s_bdone while IDLE SHALL be ignored (no state change, no master bdone).
REQ-024 Round-robin SHALL guarantee a continuously requesting master waits at most one other transfer.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, last=1 (m0 wins first tie), cnt=0; all outputs 0.
REQ-026 Reset mid-transfer SHALL drop grant and s_bstart same cycle; no bdone/berr emitted.
REQ-027 After rst deasserts, first arbitration SHALL occur on first rising edge with any breq=1.

Verification
REQ-028 Both breq=1 from reset, slave bdone 2 cycles after each bstart -> grant order m0,m1,m0,m1; each transfer separated by one IDLE cycle.
REQ-029 Only m1 requests, addr=0x100, s_rdata=0xDEADBEEF at s_bdone -> m1_rdata=0xDEADBEEF, m1_bdone one cycle, m0_rdata=0.
REQ-030 TIMEOUT=4, slave never responds -> m0_berr=m0_bdone=1 on 4th OWN0 cycle, then IDLE, then m1 granted if requesting.
REQ-031 TIMEOUT=4, s_bdone on 4th OWN cycle -> bdone=1, berr=0.
REQ-032 m0 granted, drops breq cycle 2, no s_bdone -> IDLE next cycle, no bdone, next tie still won by m0.
REQ-033 rst pulsed while OWN1 with s_bstart=1 -> s_bstart, m1_bgnt=0 immediately; after release, tie grants m0.
